// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage SPARC pipeline: tracks in-flight
// destinations, generates load-use/icc stalls, delay-slot annul, PC select and forwarding.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_valid,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic             ID_rd_used,
  input  logic             ID_RF_enable,
  input  logic             ID_load,
  input  logic             ID_CC_enable,
  input  logic             ID_uses_cc,
  input  logic             ID_branch_taken,
  input  logic             ID_annul,
  output logic             PC_LE,
  output logic             nPC_LE,
  output logic             IF_ID_LE,
  output logic             PC_sel,
  output logic             CU_bubble,
  output logic             IF_ID_flush,
  output logic [1:0]       FWD_rs1,
  output logic [1:0]       FWD_rs2,
  output logic [1:0]       FWD_rd,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] annul_count
);

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_ANNUL} state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rf_en;
    logic       load;
    logic       cc_en;
  } slot_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  state_t           r_state;
  slot_t            r_ex, r_mem, r_wb;
  logic [CNT_W-1:0] r_stall_count, r_annul_count;

  logic w_id_live, w_load_use, w_cc_haz, w_stall, w_issue, w_annul_issue;

  // %g0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic slot_match(input slot_t s, input logic [4:0] src, input logic used);
    return s.valid && s.rf_en && (s.rd == src) && (src != 5'd0) && used;
  endfunction

  // A load still in EX has no data yet; its consumer stalls and later picks it up from MEM.
  function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem, input slot_t wb,
                                         input logic [4:0] src, input logic used);
    if (slot_match(ex, src, used) && !ex.load) return SEL_EX;
    else if (slot_match(mem, src, used))       return SEL_MEM;
    else if (slot_match(wb, src, used))        return SEL_WB;
    else                                       return SEL_RF;
  endfunction

  assign w_id_live  = ID_valid && (r_state != ST_ANNUL);
  assign w_load_use = w_id_live && r_ex.load &&
                      (slot_match(r_ex, ID_rs1, ID_rs1_used) ||
                       slot_match(r_ex, ID_rs2, ID_rs2_used) ||
                       slot_match(r_ex, ID_rd,  ID_rd_used));
  assign w_cc_haz      = w_id_live && ID_uses_cc && r_ex.valid && r_ex.cc_en;
  assign w_stall       = w_load_use || w_cc_haz;
  assign w_issue       = w_id_live && !w_stall;
  assign w_annul_issue = w_issue && ID_annul;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch can be inferred.
    PC_LE       = !w_stall;
    nPC_LE      = !w_stall;
    IF_ID_LE    = !w_stall;
    CU_bubble   = !w_issue;
    PC_sel      = w_issue && ID_branch_taken;
    IF_ID_flush = w_annul_issue;
    FWD_rs1     = SEL_RF;
    FWD_rs2     = SEL_RF;
    FWD_rd      = SEL_RF;
    if (w_id_live) begin
      FWD_rs1 = fwd_sel(r_ex, r_mem, r_wb, ID_rs1, ID_rs1_used);
      FWD_rs2 = fwd_sel(r_ex, r_mem, r_wb, ID_rs2, ID_rs2_used);
      FWD_rd  = fwd_sel(r_ex, r_mem, r_wb, ID_rd,  ID_rd_used);
    end
    if (reset) begin
      PC_LE       = 1'b1;
      nPC_LE      = 1'b1;
      IF_ID_LE    = 1'b1;
      CU_bubble   = 1'b1;
      PC_sel      = 1'b0;
      IF_ID_flush = 1'b0;
      FWD_rs1     = SEL_RF;
      FWD_rs2     = SEL_RF;
      FWD_rd      = SEL_RF;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let WB<-MEM<-EX shift using pre-edge values.
    if (reset) begin
      r_state       <= ST_RUN;
      r_ex          <= '0;
      r_mem         <= '0;
      r_wb          <= '0;
      r_stall_count <= '0;
      r_annul_count <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_issue ? slot_t'{valid: 1'b1, rd: ID_rd, rf_en: ID_RF_enable,
                                 load: ID_load, cc_en: ID_CC_enable}
                       : slot_t'('0);
      if (w_stall)            r_state <= ST_STALL;
      else if (w_annul_issue) r_state <= ST_ANNUL;
      else                    r_state <= ST_RUN;
      if (w_stall && (r_stall_count != '1))       r_stall_count <= r_stall_count + 1'b1;
      if (w_annul_issue && (r_annul_count != '1)) r_annul_count <= r_annul_count + 1'b1;
    end
  end

  assign stall_count = r_stall_count;
  assign annul_count = r_annul_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (CNT_W=4): stimulus pushes expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       ID_valid;
  logic [4:0] ID_rs1, ID_rs2, ID_rd;
  logic       ID_rs1_used, ID_rs2_used, ID_rd_used;
  logic       ID_RF_enable, ID_load, ID_CC_enable, ID_uses_cc;
  logic       ID_branch_taken, ID_annul;
  logic       PC_LE, nPC_LE, IF_ID_LE, PC_sel, CU_bubble, IF_ID_flush;
  logic [1:0] FWD_rs1, FWD_rs2, FWD_rd;
  logic [3:0] stall_count, annul_count;

  pipeline_hazard_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .ID_valid(ID_valid), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used), .ID_rd_used(ID_rd_used),
    .ID_RF_enable(ID_RF_enable), .ID_load(ID_load), .ID_CC_enable(ID_CC_enable),
    .ID_uses_cc(ID_uses_cc), .ID_branch_taken(ID_branch_taken), .ID_annul(ID_annul),
    .PC_LE(PC_LE), .nPC_LE(nPC_LE), .IF_ID_LE(IF_ID_LE), .PC_sel(PC_sel),
    .CU_bubble(CU_bubble), .IF_ID_flush(IF_ID_flush),
    .FWD_rs1(FWD_rs1), .FWD_rs2(FWD_rs2), .FWD_rd(FWD_rd),
    .stall_count(stall_count), .annul_count(annul_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_u, rs2_u, rd_u, rf, ld, cc, ucc, br, an;
  } id_t;

  typedef struct {
    string      name;
    logic [11:0] out;  // {le[2:0], bubble, pc_sel, flush, f1, f2, fd}
    logic [3:0] sc;
    logic [3:0] ac;
  } entry_t;

  entry_t q[$];
  int     n_vec  = 0;
  int     n_miss = 0;
  int     exp_sc = 0;
  int     exp_ac = 0;

  function automatic logic [11:0] ex(input logic [2:0] le, input logic bub, input logic pcs,
                                     input logic fl, input logic [1:0] f1 = 2'b00,
                                     input logic [1:0] f2 = 2'b00, input logic [1:0] fd = 2'b00);
    return {le, bub, pcs, fl, f1, f2, fd};
  endfunction

  function automatic id_t i_nop();
    id_t id;
    id = '0;
    return id;
  endfunction

  function automatic id_t i_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_t id;
    id = '0;
    id.valid = 1'b1; id.rd = rd; id.rs1 = rs1; id.rs2 = rs2;
    id.rs1_u = 1'b1; id.rs2_u = 1'b1; id.rf = 1'b1;
    return id;
  endfunction

  function automatic id_t i_load(input logic [4:0] rd, input logic [4:0] rs1);
    id_t id;
    id = '0;
    id.valid = 1'b1; id.rd = rd; id.rs1 = rs1; id.rs1_u = 1'b1; id.rf = 1'b1; id.ld = 1'b1;
    return id;
  endfunction

  task automatic step(input string name, input id_t id, input logic rst, input logic [11:0] e);
    entry_t ent;
    @(posedge clk);
    #1;
    reset           = rst;
    ID_valid        = id.valid;
    ID_rs1          = id.rs1;
    ID_rs2          = id.rs2;
    ID_rd           = id.rd;
    ID_rs1_used     = id.rs1_u;
    ID_rs2_used     = id.rs2_u;
    ID_rd_used      = id.rd_u;
    ID_RF_enable    = id.rf;
    ID_load         = id.ld;
    ID_CC_enable    = id.cc;
    ID_uses_cc      = id.ucc;
    ID_branch_taken = id.br;
    ID_annul        = id.an;
    ent.name = name;
    ent.out  = e;
    ent.sc   = 4'(exp_sc);
    ent.ac   = 4'(exp_ac);
    q.push_back(ent);
    // Counters observed next cycle reflect this cycle's stall/annul, saturating at 15.
    if (rst) begin
      exp_sc = 0;
      exp_ac = 0;
    end else begin
      if (e[11:9] == 3'b000 && exp_sc < 15) exp_sc++;
      if (e[6] && exp_ac < 15)             exp_ac++;
    end
  endtask

  task automatic check(input entry_t ent);
    logic [11:0] act;
    act = {PC_LE, nPC_LE, IF_ID_LE, CU_bubble, PC_sel, IF_ID_flush, FWD_rs1, FWD_rs2, FWD_rd};
    n_vec++;
    if (act !== ent.out || stall_count !== ent.sc || annul_count !== ent.ac) begin
      n_miss++;
      $display("FAIL %s: got le=%b bub=%b pcs=%b fl=%b fwd=%b/%b/%b sc=%0d ac=%0d; need le=%b bub=%b pcs=%b fl=%b fwd=%b/%b/%b sc=%0d ac=%0d",
               ent.name, act[11:9], act[8], act[7], act[6], act[5:4], act[3:2], act[1:0],
               stall_count, annul_count, ent.out[11:9], ent.out[8], ent.out[7], ent.out[6],
               ent.out[5:4], ent.out[3:2], ent.out[1:0], ent.sc, ent.ac);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) check(q.pop_front());
  end

  initial begin
    id_t id;
    id_t use7;
    logic [11:0] iss;
    logic [11:0] stl;
    logic [11:0] rst_o;
    iss   = ex(3'b111, 1'b0, 1'b0, 1'b0);
    stl   = ex(3'b000, 1'b1, 1'b0, 1'b0);
    rst_o = ex(3'b111, 1'b1, 1'b0, 1'b0);
    use7  = i_alu(5'd8, 5'd0, 5'd7);

    reset = 1'b1;
    {ID_valid, ID_rs1, ID_rs2, ID_rd, ID_rs1_used, ID_rs2_used, ID_rd_used, ID_RF_enable,
     ID_load, ID_CC_enable, ID_uses_cc, ID_branch_taken, ID_annul} = '0;

    step("reset0", i_nop(), 1'b1, rst_o);
    step("reset1", i_load(5'd7, 5'd0), 1'b1, rst_o);

    // Forwarding chain on r3
    step("fwd_prod",  i_alu(5'd3, 5'd1, 5'd2), 1'b0, iss);
    step("fwd_ex",    i_alu(5'd4, 5'd3, 5'd2), 1'b0, ex(3'b111, 0, 0, 0, 2'b01));
    step("fwd_mem",   i_alu(5'd5, 5'd3, 5'd2), 1'b0, ex(3'b111, 0, 0, 0, 2'b10));
    step("fwd_wb",    i_alu(5'd6, 5'd3, 5'd2), 1'b0, ex(3'b111, 0, 0, 0, 2'b11));
    step("fwd_rf",    i_alu(5'd1, 5'd3, 5'd4), 1'b0, ex(3'b111, 0, 0, 0, 2'b00, 2'b11));

    // Load-use on rs2
    step("ld_r7",     i_load(5'd7, 5'd1), 1'b0, ex(3'b111, 0, 0, 0, 2'b01));
    step("lu_stall",  use7, 1'b0, stl);
    step("lu_issue",  use7, 1'b0, ex(3'b111, 0, 0, 0, 2'b00, 2'b10));

    // r0 and unused source fields
    step("ld_r0",     i_load(5'd0, 5'd0), 1'b0, iss);
    step("use_r0",    i_alu(5'd9, 5'd0, 5'd0), 1'b0, iss);
    step("ld_r5",     i_load(5'd5, 5'd0), 1'b0, iss);
    id = i_alu(5'd10, 5'd5, 5'd0);
    id.rs1_u = 1'b0;
    step("unused_rs1", id, 1'b0, iss);

    // Store data forwarded through FWD_rd
    id = '0;
    id.valid = 1'b1; id.rd = 5'd10; id.rd_u = 1'b1; id.rs1_u = 1'b1;
    step("st_fwd_rd", id, 1'b0, ex(3'b111, 0, 0, 0, 2'b00, 2'b00, 2'b01));

    // icc hazard on an annulling conditional branch
    id = i_alu(5'd11, 5'd0, 5'd0);
    id.cc = 1'b1;
    step("subcc",     id, 1'b0, iss);
    id = '0;
    id.valid = 1'b1; id.ucc = 1'b1; id.an = 1'b1;
    step("cc_stall",  id, 1'b0, stl);
    step("annul_iss", id, 1'b0, ex(3'b111, 0, 0, 1));
    id = '0;
    id.valid = 1'b1; id.ucc = 1'b1; id.br = 1'b1;
    step("annul_st",  id, 1'b0, rst_o);
    step("back_run",  i_alu(5'd12, 5'd0, 5'd0), 1'b0, iss);

    // Taken jmpl stalled by a load: target select waits for issue
    step("ld_r13",    i_load(5'd13, 5'd0), 1'b0, iss);
    id = i_alu(5'd15, 5'd13, 5'd0);
    id.rs2_u = 1'b0; id.br = 1'b1;
    step("jmpl_stall", id, 1'b0, stl);
    step("jmpl_issue", id, 1'b0, ex(3'b111, 0, 1, 0, 2'b10));

    // Repeated load-use stalls drive stall_count into saturation
    for (int i = 0; i < 20; i++) begin
      step("sat_ld",    i_load(5'd7, 5'd0), 1'b0, iss);
      step("sat_stall", use7, 1'b0, stl);
      step("sat_issue", use7, 1'b0, ex(3'b111, 0, 0, 0, 2'b00, 2'b10));
    end

    // Reset in the middle of a stall
    step("rs_ld",     i_load(5'd7, 5'd0), 1'b0, iss);
    step("rs_stall",  use7, 1'b0, stl);
    step("rs_reset",  use7, 1'b1, rst_o);
    step("rs_after",  use7, 1'b0, iss);

    // Reset in the middle of an annul
    id = '0;
    id.valid = 1'b1; id.br = 1'b1; id.an = 1'b1;
    step("ra_annul",  id, 1'b0, ex(3'b111, 0, 1, 1));
    step("ra_reset",  id, 1'b1, rst_o);
    step("ra_after",  i_alu(5'd12, 5'd0, 5'd0), 1'b0, iss);
    step("idle",      i_nop(), 1'b0, rst_o);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d entries left, need 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
